cp0_ext: RTL and testbench
==========================

// Module: cp0_ext
// PURPOSE
//   Parametrised coprocessor-0 for the 5-stage MIPS pipeline. Holds SR, Cause, EPC, PRId,
//   BadVAddr, Count and Compare. Adds synchronised, live-pending hardware interrupts, a
//   Count/Compare timer interrupt and EXL-gated precise exceptions. Sits beside the M stage.
//   Drives exc_handle to the flush/redirect logic and epc to the eret path.
// PARAMETERS
//   N_HWINT      6            external interrupt lines, 1..6, mapped to Cause/SR bits [10+i]
//   SYNC_STAGES  2            flops per hw_int synchroniser, >=1
//   TIMER_EN     1            1: Count/Compare present, timer pending ORed into IP bit 15
//   COUNT_DIV    1            Count increments once every COUNT_DIV cycles, >=1
//   PRID_VAL     32'h0000_4d31  read-only PRId value
//   SR_INIT      32'h0000_ff11  SR reset value
// PORTS
//   clk        in   1        clock, all state on rising edge
//   reset_n    in   1        asynchronous, active-low reset
//   r_addr     in   5        mfc0 register number
//   w_addr     in   5        mtc0 register number
//   we         in   1        mtc0 write strobe
//   wd         in   32       mtc0 data
//   pc_m       in   32       PC of the instruction in M
//   exc_occur  in   1        synchronous exception on the M instruction
//   exc_code   in   5        its ExcCode, valid with exc_occur
//   exc_bd     in   1        M instruction sits in a delay slot
//   bad_vaddr  in   32       faulting address for AdEL/AdES (codes 4/5)
//   eret       in   1        eret in M
//   hw_int     in   N_HWINT  asynchronous level interrupt requests
//   exc_handle out  1        take exception/interrupt this cycle (combinational)
//   epc        out  32       EPC register
//   data_out   out  32       mfc0 read data (combinational)
//   timer_irq  out  1        timer pending flag (Cause[15] timer source)
// BEHAVIOUR
//   Reset (async, reset_n=0): SR=SR_INIT; Cause=EPC=BadVAddr=Count=0; Compare=32'hffff_ffff;
//     sync chain=0; timer pending=0; div counter=0. epc=0, timer_irq=0.
//   Synchroniser: hw_int[i] passes SYNC_STAGES flops giving hs[i]. Latency SYNC_STAGES cycles.
//   Cause.IP live: Cause[10+i]<=hs[i] every cycle; Cause[15] |= timer pending when TIMER_EN.
//     Unused IP bits read 0. mtc0 to Cause writes only bits [9:8] (soft IP).
//   Timer:
//     - Count increments every COUNT_DIV cycles and wraps 32'hffff_ffff->0.
//     - Pending sets when Count==Compare on an increment edge.
//     - Pending holds until an mtc0 to Compare clears it.
//     - An mtc0 to Count loads Count and restarts the divider.
//   Interrupt request: irq = SR.IE & ~SR.EXL & |(Cause.IP_ALL[7:0] & SR.IM[7:0]), from the
//     registered Cause, so IP affects exc_handle one cycle after it updates.
//   Exception request: exc = exc_occur & ~SR.EXL. IE does not gate synchronous exceptions.
//   exc_handle = exc | irq.
//   Priority, one per edge: reset > exc_handle > eret > mtc0. A we or eret in the same
//     cycle as exc_handle is dropped.
//   On exc_handle:
//     - EPC <= exc_bd ? pc_m-4 : pc_m.
//     - SR.EXL <= 1.
//     - Cause.BD <= exc_bd.
//     - ExcCode <= exc ? exc_code : 0. A synchronous exception beats an interrupt in the
//       same cycle.
//     - BadVAddr <= bad_vaddr only when exc and exc_code is 4 or 5.
//   eret: SR.EXL <= 0. epc is already valid, zero latency.
//   mtc0 registers:
//     - Writable: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC.
//     - Ignored: 8 BadVAddr and 15 PRId are read-only; all other numbers are no-ops.
//   mfc0 registers: 8, 9, 11, 12, 13, 14 read the register; 15 reads PRID_VAL; any other
//     number reads 0. Count/Compare read 0 when TIMER_EN=0.
//   Read-during-write: data_out shows the old value; the new value appears the next cycle.
//   Reset mid-sequence: reset_n low during a pending interrupt or EXL=1 clears all state at
//     once, and no exc_handle is asserted during reset.
// TESTING
//   1 Reset: reset_n=0 asynchronously between edges -> SR=0000ff11, Cause=0, epc=0,
//     Compare=ffffffff, data_out(r15)=00004d31.
//   2 HW irq: SR=0000ff11, hw_int[2] 0->1 -> Cause[12]=1 after 2 clks; exc_handle=1 on the
//     next cycle; with pc_m=00003010 -> epc=00003010, ExcCode=0, EXL=1; exc_handle stays 0
//     while EXL=1.
//   3 Delay slot plus simultaneous events: exc_occur=1, exc_code=4, exc_bd=1, pc_m=00003024,
//     bad_vaddr=00000003, same cycle we=1 w_addr=14, hw_int pending ->
//     epc=00003020, Cause[31]=1, ExcCode=4, BadVAddr=00000003, mtc0 dropped.
//   4 Timer: COUNT_DIV=1, Compare=5, Count=0, SR=00008001 -> timer_irq=1 once Count
//     reaches 5; exc_handle with ExcCode=0; mtc0 Compare=20 clears timer_irq; Count wraps
//     ffffffff->0.
//   5 eret vs mtc0: EXL=1, eret=1 together with we to SR -> EXL=0 only, SR otherwise
//     unchanged; a later mtc0 SR=0 -> IE=0, so hw_int stays masked.

Source files
------------

// File: rtl/cp0_ext_if.sv
// cp0_ext_if: pipeline <-> coprocessor-0 bus.
//   The pipeline side (master) drives the mtc0/mfc0 addresses and data, the M-stage
//   exception information, eret and the raw interrupt lines.
//   CP0 (slave) returns exc_handle, epc, data_out and timer_irq.
//   N_HWINT sets the width of hw_int and must match the cp0_ext instance.
interface cp0_ext_if #(
    parameter int N_HWINT = 6
);
    logic [4:0]         r_addr;
    logic [4:0]         w_addr;
    logic               we;
    logic [31:0]        wd;
    logic [31:0]        pc_m;
    logic               exc_occur;
    logic [4:0]         exc_code;
    logic               exc_bd;
    logic [31:0]        bad_vaddr;
    logic               eret;
    logic [N_HWINT-1:0] hw_int;
    logic               exc_handle;
    logic [31:0]        epc;
    logic [31:0]        data_out;
    logic               timer_irq;

    modport master (
        output r_addr, w_addr, we, wd, pc_m, exc_occur, exc_code, exc_bd,
               bad_vaddr, eret, hw_int,
        input  exc_handle, epc, data_out, timer_irq
    );

    modport slave (
        input  r_addr, w_addr, we, wd, pc_m, exc_occur, exc_code, exc_bd,
               bad_vaddr, eret, hw_int,
        output exc_handle, epc, data_out, timer_irq
    );
endinterface

// File: rtl/cp0_ext.sv
// cp0_ext: coprocessor 0 for the 5-stage MIPS pipeline, sitting beside the M stage.
//   Holds SR, Cause, EPC, PRId, BadVAddr, Count and Compare. Takes synchronous exceptions
//   (gated only by SR.EXL) and interrupts (synchronised hw lines plus the Count/Compare
//   timer, gated by SR.IE, SR.EXL and SR.IM).
// Ports:
//   clk      - clock, all state on the rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - cp0_ext_if.slave: mtc0/mfc0 access, M-stage exception info, eret,
//              hw_int in; exc_handle / data_out (combinational), epc, timer_irq out
module cp0_ext #(
    parameter int          N_HWINT     = 6,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMER_EN    = 1,
    parameter int          COUNT_DIV   = 1,
    parameter logic [31:0] PRID_VAL    = 32'h0000_4d31,
    parameter logic [31:0] SR_INIT     = 32'h0000_ff11
) (
    input  logic      clk,
    input  logic      reset_n,
    cp0_ext_if.slave  bus
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [N_HWINT-1:0] r_sync [SYNC_STAGES];
    logic [31:0]        r_sr;
    logic [31:0]        r_epc;
    logic [31:0]        r_badvaddr;
    logic [31:0]        r_count;
    logic [31:0]        r_compare;
    logic [DIV_W-1:0]   r_div;
    logic               r_timer_pend;
    logic               r_cause_bd;
    logic [7:0]         r_cause_ip;   // Cause[15:8]; [1:0] soft, [7:2] hardware
    logic [4:0]         r_exc_code;

    logic [5:0]  w_hw_ip;
    logic [31:0] w_cause;
    logic [31:0] w_count_next;
    logic        w_inc;
    logic        w_irq;
    logic        w_exc;
    logic        w_exc_handle;
    logic        w_we;

    assign w_count_next = r_count + 32'd1;
    assign w_inc        = (r_div == DIV_W'(COUNT_DIV - 1));
    assign w_cause      = {r_cause_bd, 15'd0, r_cause_ip, 1'b0, r_exc_code, 2'b00};

    // Interrupts look at the registered Cause.IP, so a new IP bit acts one cycle later.
    assign w_irq = r_sr[0] & ~r_sr[1] & (|(r_cause_ip & r_sr[15:8]));
    assign w_exc = bus.exc_occur & ~r_sr[1];
    // Gated by reset_n so nothing is requested while reset is held.
    assign w_exc_handle = reset_n & (w_exc | w_irq);
    // mtc0 loses to both an exception and an eret in the same cycle.
    assign w_we = bus.we & ~w_exc_handle & ~bus.eret;

    assign bus.exc_handle = w_exc_handle;
    assign bus.epc        = r_epc;
    assign bus.timer_irq  = r_timer_pend;

    // Hardware IP image: synchronised lines, timer pending ORed into the top bit.
    always_comb begin
        w_hw_ip = 6'd0;
        for (int i = 0; i < N_HWINT; i++) begin
            w_hw_ip[i] = r_sync[SYNC_STAGES-1][i];
        end
        if (TIMER_EN != 0) begin
            w_hw_ip[5] = w_hw_ip[5] | r_timer_pend;
        end else begin
            w_hw_ip[5] = w_hw_ip[5];
        end
    end

    // mfc0 read mux; a same-cycle mtc0 is not bypassed, so the old value is returned.
    always_comb begin
        bus.data_out = 32'd0;
        case (bus.r_addr)
            5'd8:    bus.data_out = r_badvaddr;
            5'd9:    bus.data_out = (TIMER_EN != 0) ? r_count : 32'd0;
            5'd11:   bus.data_out = (TIMER_EN != 0) ? r_compare : 32'd0;
            5'd12:   bus.data_out = r_sr;
            5'd13:   bus.data_out = w_cause;
            5'd14:   bus.data_out = r_epc;
            5'd15:   bus.data_out = PRID_VAL;
            default: bus.data_out = 32'd0;
        endcase
    end

    // hw_int synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.hw_int;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Count/Compare timer. Pending sets on the increment edge where Count reaches Compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= 32'd0;
            r_compare    <= 32'hffff_ffff;
            r_div        <= '0;
            r_timer_pend <= 1'b0;
        end else if (TIMER_EN != 0) begin
            if (w_we && (bus.w_addr == 5'd9)) begin
                r_count <= bus.wd;
                r_div   <= '0;
            end else if (w_inc) begin
                r_count <= w_count_next;
                r_div   <= '0;
            end else begin
                r_div   <= r_div + DIV_W'(1);
            end
            if (w_we && (bus.w_addr == 5'd11)) begin
                r_compare    <= bus.wd;
                r_timer_pend <= 1'b0;
            end else if (w_inc && (w_count_next == r_compare)
                         && !(w_we && (bus.w_addr == 5'd9))) begin
                r_timer_pend <= 1'b1;
            end else begin
                r_timer_pend <= r_timer_pend;
            end
        end else begin
            r_count      <= r_count;
            r_timer_pend <= 1'b0;
        end
    end

    // Architectural state: live IP, then exception > eret > mtc0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr       <= SR_INIT;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_cause_bd <= 1'b0;
            r_cause_ip <= 8'd0;
            r_exc_code <= 5'd0;
        end else begin
            r_cause_ip[7:2] <= w_hw_ip;
            if (w_exc_handle) begin
                r_epc      <= bus.exc_bd ? (bus.pc_m - 32'd4) : bus.pc_m;
                r_sr[1]    <= 1'b1;
                r_cause_bd <= bus.exc_bd;
                r_exc_code <= w_exc ? bus.exc_code : 5'd0;
                if (w_exc && ((bus.exc_code == 5'd4) || (bus.exc_code == 5'd5))) begin
                    r_badvaddr <= bus.bad_vaddr;
                end else begin
                    r_badvaddr <= r_badvaddr;
                end
            end else if (bus.eret) begin
                r_sr[1] <= 1'b0;
            end else if (w_we) begin
                case (bus.w_addr)
                    5'd12:   r_sr            <= bus.wd;
                    5'd13:   r_cause_ip[1:0] <= bus.wd[9:8];
                    5'd14:   r_epc           <= bus.wd;
                    default: r_sr            <= r_sr;
                endcase
            end else begin
                r_sr <= r_sr;
            end
        end
    end
endmodule

// File: tb/tb_cp0_ext.sv
module tb_cp0_ext;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cp0_ext_if #(.N_HWINT(6)) bus();

    cp0_ext #(
        .N_HWINT(6), .SYNC_STAGES(2), .TIMER_EN(1), .COUNT_DIV(1),
        .PRID_VAL(32'h0000_4d31), .SR_INIT(32'h0000_ff11)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [4:0]  w_addr;
        logic [31:0] wd;
        logic [4:0]  r_addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.r_addr = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we     = 1'b1;
        bus.w_addr = a;
        bus.wd     = d;
        tick();
        bus.we     = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        bit          seen;

        reset_n       = 1'b1;
        bus.r_addr    = 5'd0;
        bus.w_addr    = 5'd0;
        bus.we        = 1'b0;
        bus.wd        = 32'd0;
        bus.pc_m      = 32'd0;
        bus.exc_occur = 1'b0;
        bus.exc_code  = 5'd0;
        bus.exc_bd    = 1'b0;
        bus.bad_vaddr = 32'd0;
        bus.eret      = 1'b0;
        bus.hw_int    = 6'd0;

        vecs[0] = '{"wr_sr0",      5'd12, 32'h0000_0000, 5'd12, 32'h0000_0000};
        vecs[1] = '{"wr_epc",      5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
        vecs[2] = '{"wr_compare",  5'd11, 32'h0000_0100, 5'd11, 32'h0000_0100};
        vecs[3] = '{"wr_count",    5'd9,  32'h0000_0040, 5'd9,  32'h0000_0040};
        vecs[4] = '{"wr_cause",    5'd13, 32'hffff_ffff, 5'd13, 32'h0000_0300};
        vecs[5] = '{"ro_badvaddr", 5'd8,  32'hdead_beef, 5'd8,  32'h0000_0000};
        vecs[6] = '{"ro_prid",     5'd15, 32'h0000_0000, 5'd15, 32'h0000_4d31};
        vecs[7] = '{"noop_reg3",   5'd3,  32'hffff_ffff, 5'd3,  32'h0000_0000};
        vecs[8] = '{"wr_cause0",   5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
        vecs[9] = '{"wr_sr_ff00",  5'd12, 32'h0000_ff00, 5'd12, 32'h0000_ff00};

        // Reset asserted between edges
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        rd(5'd12, d); chk("rst_sr", d, 32'h0000_ff11);
        rd(5'd13, d); chk("rst_cause", d, 32'h0000_0000);
        chk("rst_epc", bus.epc, 32'h0000_0000);
        rd(5'd11, d); chk("rst_compare", d, 32'hffff_ffff);
        rd(5'd15, d); chk("rst_prid", d, 32'h0000_4d31);
        chk("rst_timer_irq", {31'd0, bus.timer_irq}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Register write/read table
        for (int i = 0; i < 10; i++) begin
            mtc0(vecs[i].w_addr, vecs[i].wd);
            rd(vecs[i].r_addr, d);
            chk(vecs[i].name, d, vecs[i].exp);
        end

        // Read during write returns the old value
        bus.we = 1'b1; bus.w_addr = 5'd14; bus.wd = 32'hcafe_0000;
        rd(5'd14, d); chk("rdw_old", d, 32'h1234_5678);
        tick();
        bus.we = 1'b0;
        rd(5'd14, d); chk("rdw_new", d, 32'hcafe_0000);
        mtc0(5'd11, 32'hffff_0000);

        // Hardware interrupt
        mtc0(5'd12, 32'h0000_ff11);
        bus.pc_m   = 32'h0000_3010;
        bus.r_addr = 5'd13;
        bus.hw_int = 6'b000100;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            rd(5'd13, d);
            if (d[12]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("hwirq_cause12", {31'd0, seen}, 32'd1);
        chk("hwirq_exc_handle", {31'd0, bus.exc_handle}, 32'd1);
        tick();
        chk("hwirq_epc", bus.epc, 32'h0000_3010);
        rd(5'd12, d); chk("hwirq_sr_exl", d, 32'h0000_ff13);
        rd(5'd13, d); chk("hwirq_exccode", {27'd0, d[6:2]}, 32'd0);
        chk("hwirq_masked_exl", {31'd0, bus.exc_handle}, 32'd0);
        tick();
        chk("hwirq_still_masked", {31'd0, bus.exc_handle}, 32'd0);

        // Delay-slot exception with a pending irq and a same-cycle mtc0
        bus.eret = 1'b1;
        tick();
        bus.eret      = 1'b0;
        bus.exc_occur = 1'b1;
        bus.exc_code  = 5'd4;
        bus.exc_bd    = 1'b1;
        bus.pc_m      = 32'h0000_3024;
        bus.bad_vaddr = 32'h0000_0003;
        bus.we = 1'b1; bus.w_addr = 5'd14; bus.wd = 32'haaaa_0000;
        #1;
        chk("ds_exc_handle", {31'd0, bus.exc_handle}, 32'd1);
        tick();
        bus.exc_occur = 1'b0; bus.exc_bd = 1'b0; bus.we = 1'b0;
        chk("ds_epc", bus.epc, 32'h0000_3020);
        rd(5'd13, d); chk("ds_bd", {31'd0, d[31]}, 32'd1);
        chk("ds_exccode", {27'd0, d[6:2]}, 32'd4);
        rd(5'd8, d); chk("ds_badvaddr", d, 32'h0000_0003);
        bus.hw_int = 6'd0;
        for (int k = 0; k < 4; k++) tick();

        // eret wins over a same-cycle mtc0 to SR
        bus.eret = 1'b1;
        bus.we = 1'b1; bus.w_addr = 5'd12; bus.wd = 32'h0000_0000;
        tick();
        bus.eret = 1'b0; bus.we = 1'b0;
        rd(5'd12, d); chk("eret_sr", d, 32'h0000_ff11);
        chk("eret_no_exc", {31'd0, bus.exc_handle}, 32'd0);
        mtc0(5'd12, 32'h0000_0000);
        rd(5'd12, d); chk("sr_cleared", d, 32'h0000_0000);
        bus.hw_int = 6'b000001;
        for (int k = 0; k < 4; k++) tick();
        rd(5'd13, d); chk("ie0_cause10", {31'd0, d[10]}, 32'd1);
        chk("ie0_masked", {31'd0, bus.exc_handle}, 32'd0);
        bus.hw_int = 6'd0;
        for (int k = 0; k < 4; k++) tick();

        // Timer
        bus.pc_m = 32'h0000_4000;
        mtc0(5'd11, 32'h0000_0005);
        chk("tmr_clr0", {31'd0, bus.timer_irq}, 32'd0);
        mtc0(5'd9, 32'h0000_0000);
        mtc0(5'd12, 32'h0000_8001);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.timer_irq) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("tmr_seen", {31'd0, seen}, 32'd1);
        rd(5'd9, d); chk("tmr_count5", d, 32'h0000_0005);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.exc_handle) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("tmr_exc_handle", {31'd0, seen}, 32'd1);
        tick();
        chk("tmr_epc", bus.epc, 32'h0000_4000);
        rd(5'd12, d); chk("tmr_sr", d, 32'h0000_8003);
        rd(5'd13, d); chk("tmr_exccode", {27'd0, d[6:2]}, 32'd0);
        tick(); tick();
        chk("tmr_hold", {31'd0, bus.timer_irq}, 32'd1);
        mtc0(5'd11, 32'h0000_0020);
        chk("tmr_cleared", {31'd0, bus.timer_irq}, 32'd0);
        mtc0(5'd9, 32'hffff_fffe);
        rd(5'd9, d); chk("wrap_load", d, 32'hffff_fffe);
        tick();
        rd(5'd9, d); chk("wrap_max", d, 32'hffff_ffff);
        tick();
        rd(5'd9, d); chk("wrap_zero", d, 32'h0000_0000);

        // Reset in the middle of activity (EXL=1, pending line, exc_occur)
        bus.hw_int    = 6'b000010;
        bus.exc_occur = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_exc_handle", {31'd0, bus.exc_handle}, 32'd0);
        rd(5'd12, d); chk("mid_rst_sr", d, 32'h0000_ff11);
        rd(5'd9, d); chk("mid_rst_count", d, 32'h0000_0000);
        rd(5'd13, d); chk("mid_rst_cause", d, 32'h0000_0000);
        chk("mid_rst_epc", bus.epc, 32'h0000_0000);
        tick();
        chk("mid_rst_hold_exc", {31'd0, bus.exc_handle}, 32'd0);
        bus.exc_occur = 1'b0;
        bus.hw_int    = 6'd0;
        reset_n       = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
